// File: rtl/if_stage_if.sv
// IF-stage control inputs (stall/redirect) and the IF/ID pipeline register outputs.
// Latency: n/a (bundle of wires only).
// Backpressure: stall from the hazard unit is the only hold signal; redirect flushes.
interface if_stage_if;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instruction;
    logic        if_id_valid;
    logic        halted;

    // Driver side: hazard unit / EXE stage, consumer of IF/ID.
    modport master (
        output stall,
        output redirect_valid,
        output redirect_pc,
        input  if_id_pc,
        input  if_id_pc_plus4,
        input  if_id_instruction,
        input  if_id_valid,
        input  halted
    );

    // Fetch stage side.
    modport slave (
        input  stall,
        input  redirect_valid,
        input  redirect_pc,
        output if_id_pc,
        output if_id_pc_plus4,
        output if_id_instruction,
        output if_id_valid,
        output halted
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch: PC register, word-addressed instruction ROM, IF/ID register, halt detection.
// Latency: 1 cycle PC -> IF/ID; a redirect costs one bubble.
// Backpressure: stall holds PC and IF/ID; redirect beats stall and halt.
module if_stage #(
    parameter int          IM_DEPTH  = 256,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFC00_0000
) (
    input  logic        clock,
    input  logic        reset,
    if_stage_if.slave   bus
);
    localparam int AW = $clog2(IM_DEPTH);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] instruction;
        logic        valid;
    } if_id_t;

    localparam if_id_t BUBBLE = '{pc: 32'h0, pc_plus4: 32'h0, instruction: 32'h0, valid: 1'b0};

    // Preloaded from outside the block; never written here and untouched by reset.
    logic [31:0] ins_memory [0:IM_DEPTH-1];

    // Debug-visible program counter.
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic [31:0] fetch_word;

    state_t state, state_next;
    if_id_t if_id, if_id_next;

    // Byte address bits [1:0] are ignored; upper bits wrap modulo the depth.
    assign fetch_word = ins_memory[pc[AW+1:2]];
    assign pc_plus4   = pc + 32'd4;

    // Next-state: redirect > stall > halted > halt fetch > normal advance.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        if_id_next = if_id;
        if (bus.redirect_valid) begin
            // Younger instructions are wrong-path, including a fetched halt.
            pc_next    = bus.redirect_pc;
            if_id_next = BUBBLE;
            state_next = RUN;
        end else if (bus.stall) begin
            // Hold everything.
        end else if (state == HALTED) begin
            if_id_next = BUBBLE;
        end else if (fetch_word == HALT_WORD) begin
            // The halt word itself never enters IF/ID.
            if_id_next = BUBBLE;
            state_next = HALTED;
        end else begin
            if_id_next = '{pc: pc, pc_plus4: pc_plus4, instruction: fetch_word, valid: 1'b1};
            pc_next    = pc_plus4;
        end
    end

    // State, PC and IF/ID registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RUN;
            pc    <= RESET_PC;
            if_id <= BUBBLE;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if_id <= if_id_next;
        end
    end

    assign bus.if_id_pc          = if_id.pc;
    assign bus.if_id_pc_plus4    = if_id.pc_plus4;
    assign bus.if_id_instruction = if_id.instruction;
    assign bus.if_id_valid       = if_id.valid;
    assign bus.halted            = (state == HALTED);
endmodule
